// File: rtl/othello_pkg.sv
// Shared constants and types for the othello turn sequencer.
// Cell/side encodings, board direction bits and turn-state codes.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] SIDE_A     = 2'b10;
  localparam logic [1:0] SIDE_B     = 2'b11;

  localparam int DIR_UP    = 0;
  localparam int DIR_RIGHT = 2;
  localparam int DIR_DOWN  = 4;
  localparam int DIR_LEFT  = 6;

  localparam logic [2:0] CURSOR_HOME = 3'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DET,
    ST_SETTLE,
    ST_EVAL,
    ST_WRITE,
    ST_GAP,
    ST_TOGGLE,
    ST_OVER
  } turn_state_e;

  function automatic logic [1:0] other_side(input logic [1:0] s);
    return {s[1], ~s[0]};
  endfunction

endpackage

// File: rtl/othello_turn_ctrl_cursor.sv
// Wrap-around 8x8 cursor; opposing pulses in one cycle cancel.
// Moves only while en_i is high.
module othello_turn_ctrl_cursor
  import othello_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       en_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [2:0] x_o,
  output logic [2:0] y_o
);

  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (left_i && !right_i)
        x_d = x_q - 3'd1;
      else if (right_i && !left_i)
        x_d = x_q + 3'd1;
      if (up_i && !down_i)
        y_d = y_q - 3'd1;
      else if (down_i && !up_i)
        y_d = y_q + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q <= CURSOR_HOME;
      y_q <= CURSOR_HOME;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/othello_turn_ctrl.sv
// Othello turn sequencer: cursor, side to move, and the
// check/detect/flip/toggle handshake with the board RAM.
module othello_turn_ctrl
  import othello_pkg::*;
#(
  parameter int         HOLD_CYCLES   = 2,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [1:0] FIRST_SIDE    = SIDE_A,
  parameter int         MAX_MOVES     = 60
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_place,
  input  logic       btn_pass,
  input  logic [1:0] q,
  input  logic [7:0] dir,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [1:0] side,
  output logic       detecten,
  output logic       writeen,
  output logic       busy,
  output logic       illegal,
  output logic       game_over,
  output logic [5:0] move_count
);

  localparam int CW = 8;
  localparam logic [CW-1:0] HOLD_RLD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_RLD = CW'(SETTLE_CYCLES - 1);

  turn_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    side_q;
  logic [1:0]    pass_q;
  logic [5:0]    mc_q;
  logic          det_q, wr_q, busy_q, ill_q, over_q;
  logic [5:0]    mc_inc;
  logic          cur_en;

  assign cur_en = (state_q == ST_IDLE) && !btn_place && !btn_pass;
  assign mc_inc = (mc_q == 6'd63) ? mc_q : mc_q + 6'd1;

  othello_turn_ctrl_cursor u_cursor (
    .clock   (clock),
    .resetn  (resetn),
    .en_i    (cur_en),
    .left_i  (btn_left),
    .right_i (btn_right),
    .up_i    (btn_up),
    .down_i  (btn_down),
    .x_o     (x),
    .y_o     (y)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      side_q  <= FIRST_SIDE;
      pass_q  <= 2'd0;
      mc_q    <= 6'd0;
      det_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ill_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (btn_place) begin
            state_q <= ST_CHECK;
            busy_q  <= 1'b1;
          end else if (btn_pass) begin
            side_q <= other_side(side_q);
            if (pass_q == 2'd1) begin
              pass_q  <= 2'd2;
              state_q <= ST_OVER;
              over_q  <= 1'b1;
            end else begin
              pass_q <= pass_q + 2'd1;
            end
          end
        end
        ST_CHECK: begin
          if (q != CELL_EMPTY) begin
            ill_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= HOLD_RLD;
            det_q   <= 1'b1;
            state_q <= ST_DET;
          end
        end
        ST_DET: begin
          if (cnt_q == '0) begin
            cnt_q   <= SETTLE_RLD;
            det_q   <= 1'b0;
            state_q <= ST_SETTLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0)
            state_q <= ST_EVAL;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        ST_EVAL: begin
          if (dir == 8'd0) begin
            ill_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= HOLD_RLD;
            wr_q    <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (cnt_q == '0) begin
            wr_q    <= 1'b0;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_GAP: state_q <= ST_TOGGLE;
        ST_TOGGLE: begin
          side_q <= other_side(side_q);
          mc_q   <= mc_inc;
          pass_q <= 2'd0;
          busy_q <= 1'b0;
          if (int'(mc_inc) >= MAX_MOVES) begin
            state_q <= ST_OVER;
            over_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_OVER: state_q <= ST_OVER;
        default: begin
          state_q <= ST_IDLE;
          det_q   <= 1'b0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign side       = side_q;
  assign detecten   = det_q;
  assign writeen    = wr_q;
  assign busy       = busy_q;
  assign illegal    = ill_q;
  assign game_over  = over_q;
  assign move_count = mc_q;

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Bench for othello_turn_ctrl: cursor vector table, timed traces of
// the placement sequences, and random play against a move-level model.
module tb_othello_turn_ctrl;
  import othello_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0;
  logic       btn_place = 1'b0, btn_pass = 1'b0;
  logic [1:0] q = 2'b00;
  logic [7:0] dir = 8'h00;
  logic [2:0] x, y;
  logic [1:0] side;
  logic       detecten, writeen, busy, illegal, game_over;
  logic [5:0] move_count;

  othello_turn_ctrl dut (
    .clock      (clock),
    .resetn     (resetn),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_place  (btn_place),
    .btn_pass   (btn_pass),
    .q          (q),
    .dir        (dir),
    .x          (x),
    .y          (y),
    .side       (side),
    .detecten   (detecten),
    .writeen    (writeen),
    .busy       (busy),
    .illegal    (illegal),
    .game_over  (game_over),
    .move_count (move_count)
  );

  always #5 clock = ~clock;

  int vec_n = 0;
  int err_n = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_btn();
    btn_left = 0; btn_right = 0; btn_up = 0;
    btn_down = 0; btn_place = 0; btn_pass = 0;
  endtask

  task automatic do_reset();
    clr_btn();
    resetn = 1'b0;
    #2;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  function automatic logic [12:1] mask(input int lo, input int hi);
    logic [12:1] m;
    for (int k = 1; k <= 12; k++) m[k] = (k >= lo && k <= hi);
    return m;
  endfunction

  // ---------------- cursor vector table ----------------
  typedef struct {
    logic       l, r, u, d;
    logic [2:0] ex, ey;
  } cur_vec_t;
  cur_vec_t cv[14];

  // ---------------- placement traces ----------------
  logic [12:1] det_t, wr_t, ill_t, busy_t;

  task automatic place_trace(input logic [1:0] qv, input logic [7:0] dv,
                             input bit noise);
    q = qv; dir = dv;
    btn_place = 1'b1;
    tick();
    btn_place = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      det_t[k]  = detecten;
      wr_t[k]   = writeen;
      ill_t[k]  = illegal;
      busy_t[k] = busy;
      if (noise && k == 3) begin
        btn_left = 1; btn_pass = 1; btn_place = 1;
      end
      tick();
      clr_btn();
    end
  endtask

  // ---------------- move-level reference model ----------------
  int         mx, my, mmc, mpass;
  logic [1:0] mside;
  bit         mover;

  task automatic model_reset();
    mx = 3; my = 3; mmc = 0; mpass = 0;
    mside = SIDE_A; mover = 0;
  endtask

  // kind 0 cursor (b = {down,up,right,left}), 1 pass, 2 place
  task automatic act(input int kind, input logic [3:0] b,
                     input logic [1:0] qv, input logic [7:0] dv);
    int eb, ei, nb, ni;
    eb = 0; ei = 0;
    if (!mover) begin
      if (kind == 0) begin
        mx = (mx + int'(b[1]) - int'(b[0]) + 8) % 8;
        my = (my + int'(b[3]) - int'(b[2]) + 8) % 8;
      end else if (kind == 1) begin
        mside[0] = ~mside[0];
        mpass++;
        if (mpass >= 2) mover = 1;
      end else if (qv != 2'b00) begin
        eb = 1; ei = 1;
      end else if (dv == 8'h00) begin
        eb = 6; ei = 1;
      end else begin
        eb = 10;
        mside[0] = ~mside[0];
        mmc = (mmc >= 63) ? 63 : mmc + 1;
        mpass = 0;
        if (mmc >= 60) mover = 1;
      end
    end
    q = qv; dir = dv;
    if (kind == 0) begin
      btn_left = b[0]; btn_right = b[1];
      btn_up = b[2]; btn_down = b[3];
    end
    btn_pass  = (kind == 1);
    btn_place = (kind == 2);
    tick();
    clr_btn();
    nb = 0; ni = 0;
    while (busy === 1'b1 && nb < 20) begin
      nb++;
      ni += int'(illegal);
      chk("det_wr_exclusive", {31'd0, detecten & writeen}, 0);
      if ($urandom_range(0, 3) == 0) begin
        {btn_left, btn_right, btn_up, btn_down} = 4'($urandom);
        {btn_place, btn_pass} = 2'($urandom);
      end
      tick();
      clr_btn();
    end
    ni += int'(illegal);
    chk("rnd_busy_cycles", nb, eb);
    chk("rnd_illegal_pulses", ni, ei);
    chk("rnd_x", {29'd0, x}, mx);
    chk("rnd_y", {29'd0, y}, my);
    chk("rnd_side", {30'd0, side}, {30'd0, mside});
    chk("rnd_move_count", {26'd0, move_count}, mmc);
    chk("rnd_game_over", {31'd0, game_over}, {31'd0, mover});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cv[0]  = '{0,0,1,0, 3'd3, 3'd2};
    cv[1]  = '{1,0,0,0, 3'd2, 3'd2};
    cv[2]  = '{1,0,0,0, 3'd1, 3'd2};
    cv[3]  = '{1,0,0,0, 3'd0, 3'd2};
    cv[4]  = '{0,0,0,1, 3'd0, 3'd3};
    cv[5]  = '{0,0,0,1, 3'd0, 3'd4};
    cv[6]  = '{0,0,0,1, 3'd0, 3'd5};
    cv[7]  = '{0,0,0,1, 3'd0, 3'd6};
    cv[8]  = '{0,0,0,1, 3'd0, 3'd7};
    cv[9]  = '{1,0,0,1, 3'd7, 3'd0};
    cv[10] = '{1,1,0,0, 3'd7, 3'd0};
    cv[11] = '{0,0,1,1, 3'd7, 3'd0};
    cv[12] = '{1,1,1,0, 3'd7, 3'd7};
    cv[13] = '{0,1,0,1, 3'd0, 3'd0};

    // reset state
    do_reset();
    chk("rst_x", {29'd0, x}, 3);
    chk("rst_y", {29'd0, y}, 3);
    chk("rst_side", {30'd0, side}, {30'd0, SIDE_A});
    chk("rst_outs", {26'd0, detecten, writeen, busy, illegal, game_over, 1'b0}, 0);
    chk("rst_move_count", {26'd0, move_count}, 0);

    // cursor table
    foreach (cv[i]) begin
      btn_left = cv[i].l; btn_right = cv[i].r;
      btn_up = cv[i].u; btn_down = cv[i].d;
      tick();
      clr_btn();
      chk($sformatf("cursor_x[%0d]", i), {29'd0, x}, {29'd0, cv[i].ex});
      chk($sformatf("cursor_y[%0d]", i), {29'd0, y}, {29'd0, cv[i].ey});
    end

    // legal move at (3,2): place pulse in cycle 0
    do_reset();
    btn_up = 1'b1;
    tick();
    clr_btn();
    place_trace(2'b00, 8'h01 << DIR_DOWN, 0);
    chk("legal_detecten", det_t, mask(2, 3));
    chk("legal_writeen", wr_t, mask(7, 8));
    chk("legal_busy", busy_t, mask(1, 10));
    chk("legal_illegal", ill_t, 0);
    chk("legal_side", {30'd0, side}, {30'd0, SIDE_B});
    chk("legal_move_count", {26'd0, move_count}, 1);
    chk("legal_xy", {26'd0, x, y}, {26'd0, 3'd3, 3'd2});

    // buttons while busy are dropped
    place_trace(2'b00, 8'h01 << DIR_UP, 1);
    chk("noise_busy", busy_t, mask(1, 10));
    chk("noise_writeen", wr_t, mask(7, 8));
    chk("noise_side", {30'd0, side}, {30'd0, SIDE_A});
    chk("noise_move_count", {26'd0, move_count}, 2);
    chk("noise_xy", {26'd0, x, y}, {26'd0, 3'd3, 3'd2});

    // occupied cell
    place_trace(SIDE_B, 8'hff, 0);
    chk("occ_illegal", ill_t, mask(2, 2));
    chk("occ_busy", busy_t, mask(1, 1));
    chk("occ_det_wr", {det_t, wr_t}, 0);
    chk("occ_side", {30'd0, side}, {30'd0, SIDE_A});
    chk("occ_move_count", {26'd0, move_count}, 2);

    // empty cell, nothing to flip
    place_trace(2'b00, 8'h00, 0);
    chk("noflip_detecten", det_t, mask(2, 3));
    chk("noflip_illegal", ill_t, mask(7, 7));
    chk("noflip_busy", busy_t, mask(1, 6));
    chk("noflip_writeen", wr_t, 0);
    chk("noflip_side", {30'd0, side}, {30'd0, SIDE_A});

    // two passes end the game; OVER ignores buttons
    do_reset();
    btn_pass = 1'b1; tick(); clr_btn();
    chk("pass1_side", {30'd0, side}, {30'd0, SIDE_B});
    chk("pass1_over", {31'd0, game_over}, 0);
    btn_pass = 1'b1; tick(); clr_btn();
    chk("pass2_over", {31'd0, game_over}, 1);
    chk("pass2_side", {30'd0, side}, {30'd0, SIDE_A});
    btn_place = 1'b1; btn_left = 1'b1; tick(); clr_btn();
    tick();
    chk("over_ignored", {28'd0, busy, x}, {28'd0, 1'b0, 3'd3});

    // pass, legal move, pass: pass count cleared by the move
    do_reset();
    btn_pass = 1'b1; tick(); clr_btn();
    place_trace(2'b00, 8'h01 << DIR_LEFT, 0);
    btn_pass = 1'b1; tick(); clr_btn();
    chk("pmp_over", {31'd0, game_over}, 0);
    chk("pmp_side", {30'd0, side}, {30'd0, SIDE_B});

    // reset in the middle of WRITE
    do_reset();
    btn_right = 1'b1; tick(); clr_btn();
    q = 2'b00; dir = 8'h01 << DIR_RIGHT;
    btn_place = 1'b1; tick(); btn_place = 1'b0;
    repeat (6) tick();
    chk("midwr_writeen_hi", {31'd0, writeen}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midwr_writeen_drop", {31'd0, writeen}, 0);
    chk("midwr_outs", {26'd0, detecten, busy, illegal, game_over, 2'b00}, 0);
    chk("midwr_xy_side", {24'd0, x, y, side}, {24'd0, 3'd3, 3'd3, SIDE_A});
    chk("midwr_move_count", {26'd0, move_count}, 0);
    tick();
    resetn = 1'b1;

    // random play against the model
    do_reset();
    model_reset();
    for (int it = 0; it < 500; it++) begin
      int r;
      logic [1:0] qv;
      logic [7:0] dv;
      if (mover) begin
        do_reset();
        model_reset();
      end
      r  = $urandom_range(0, 15);
      qv = ($urandom_range(0, 3) == 0) ?
           (($urandom_range(0, 1) == 0) ? SIDE_A : SIDE_B) : CELL_EMPTY;
      dv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if (r < 7)
        act(0, 4'($urandom_range(1, 15)), qv, dv);
      else if (r == 7)
        act(1, 4'd0, qv, dv);
      else
        act(2, 4'd0, qv, dv);
    end

    // sixty legal moves end the game
    do_reset();
    model_reset();
    for (int m = 0; m < 60; m++)
      act(2, 4'd0, 2'b00, 8'($urandom_range(1, 255)));
    act(2, 4'd0, 2'b00, 8'hff);
    act(1, 4'd0, 2'b00, 8'hff);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
